// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  function automatic int baud_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    int d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one-clock tick every DIV clocks, restartable.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver with valid/ready byte output.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 rx_busy
);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam bit ODD = (PARITY_ODD != 0);
  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int H   = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_LO  = TW'(H - 1);
  localparam logic [TW-1:0] T_MID = TW'(H);
  localparam logic [TW-1:0] T_HI  = TW'(H + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  uart_rx_state_e state;

  logic                 s1, s2, prev;
  logic                 fall, tick, decide, vote;
  logic                 smp_a, smp_b, brk, pbit;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= rx;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign fall = prev && !s2;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear ((state == IDLE) && fall),
    .tick  (tick)
  );

  // Two-of-three vote around the bit centre; third sample is live.
  assign vote    = (smp_a & smp_b) | (smp_a & s2) | (smp_b & s2);
  assign decide  = tick && (tcnt == T_HI);
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      bcnt          <= '0;
      shift         <= '0;
      smp_a         <= 1'b0;
      smp_b         <= 1'b0;
      brk           <= 1'b0;
      pbit          <= 1'b0;
      data_out      <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (state != IDLE && tick) begin
        tcnt <= (tcnt == T_END) ? '0 : tcnt + 1'b1;
        if (tcnt == T_LO) smp_a <= s2;
        if (tcnt == T_MID) smp_b <= s2;
      end

      unique case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            tcnt  <= '0;
          end
        end
        START: begin
          if (tick && tcnt == T_LO && s2) begin
            state <= IDLE;
          end else if (tick && tcnt == T_END) begin
            state <= DATA;
            bcnt  <= '0;
          end
        end
        DATA: begin
          if (decide) begin
            shift <= {vote, shift[DATA_BITS-1:1]};
            if (bcnt == B_END) begin
              bcnt  <= '0;
              state <= PAR_EN ? PARITY : STOP;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (decide) begin
            pbit  <= vote;
            state <= STOP;
          end
        end
        STOP: begin
          if (brk) begin
            if (s2) begin
              brk   <= 1'b0;
              state <= IDLE;
            end
          end else if (decide) begin
            if (rx_valid && !rx_ready) begin
              overrun <= 1'b1;
            end else begin
              data_out      <= shift;
              framing_error <= !vote;
              parity_error  <= PAR_EN && (pbit != ((^shift) ^ ODD));
              rx_valid      <= 1'b1;
            end
            if (vote) state <= IDLE;
            else brk <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
